// File: rtl/spi_ram_pkg.sv
// Shared opcodes and read-engine state encoding for spi_burst_ram.
// Latency / backpressure: none (definitions only).
// Burst reads are compiled in when SPI_RAM_BURST_EN is defined.
package spi_ram_pkg;

    localparam logic [1:0] OP_SET_WADDR = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_SET_RADDR = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_HOLD = 2'b10
    } rd_state_t;

endpackage

// File: rtl/spi_ram_array.sv
// Storage array: one synchronous write port, one combinational read port.
// Latency: write lands on the next rising edge; read data follows raddr in the same cycle.
// Backpressure: none; the parent owns all flow control.
module spi_ram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_burst_ram.sv
// Command-driven RAM behind the SPI slave; SPI_RAM_BURST_EN enables multi-word READ bursts.
// Latency: READ command cycle to first tx_valid word is 2 cycles; one word per cycle after.
// Backpressure: tx_data holds until tx_ready; commands arriving while busy are dropped (cmd_drop).
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int BURST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              cmd_drop
);

    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("ADDR_W must not exceed DATA_W");
    end
    if (BURST_W > DATA_W) begin : g_bad_burst_w
        $error("BURST_W must not exceed DATA_W");
    end

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic              cmd_ok;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              tx_valid_d;
    logic [DATA_W-1:0] tx_data_d;
    logic              cmd_drop_d;
    logic              last_word;
`ifdef SPI_RAM_BURST_EN
    logic [BURST_W-1:0] cnt_q, cnt_d;
`endif

    assign opcode  = rx_data[DATA_W+1:DATA_W];
    assign payload = rx_data[DATA_W-1:0];
    assign busy    = (state_q != ST_IDLE);
    assign cmd_ok  = rx_valid && !busy;
    assign mem_we  = cmd_ok && (opcode == OP_WRITE);

`ifdef SPI_RAM_BURST_EN
    assign last_word = (cnt_q == '0);
`else
    assign last_word = 1'b1;
`endif

    spi_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (waddr_q),
        .wdata (payload),
        .raddr (raddr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        cmd_drop_d = rx_valid && busy;
`ifdef SPI_RAM_BURST_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_ok) begin
                    case (opcode)
                        OP_SET_WADDR: waddr_d = payload[ADDR_W-1:0];
                        OP_WRITE:     waddr_d = waddr_q + ADDR_W'(1);
                        OP_SET_RADDR: raddr_d = payload[ADDR_W-1:0];
                        default: begin
`ifdef SPI_RAM_BURST_EN
                            cnt_d = payload[BURST_W-1:0];
`endif
                            state_d = ST_RD;
                        end
                    endcase
                end
            end
            ST_RD: begin
                tx_data_d  = mem_rdata;
                raddr_d    = raddr_q + ADDR_W'(1);
                tx_valid_d = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (tx_valid && tx_ready) begin
                    if (last_word) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        // Next word is fetched on the handshake edge to sustain one word per cycle.
                        tx_data_d = mem_rdata;
                        raddr_d   = raddr_q + ADDR_W'(1);
`ifdef SPI_RAM_BURST_EN
                        cnt_d     = cnt_q - BURST_W'(1);
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            waddr_q  <= '0;
            raddr_q  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            cmd_drop <= 1'b0;
`ifdef SPI_RAM_BURST_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
            cmd_drop <= cmd_drop_d;
`ifdef SPI_RAM_BURST_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule
